// File: rtl/am25ls2548_pkg.sv
// Shared definitions for the Am25LS2548 decoder bus initiator: FSM
// encoding, default timing constants and a reference decode helper.
package am25ls2548_pkg;

  // Bus-cycle phases, exported on the debug state port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Default address/enable setup time before the strobe, in clocks (1..7).
  localparam int unsigned DEF_SETUP_CYC = 1;
  // Default maximum strobe length waiting for ack_, in clocks (1..15).
  localparam int unsigned DEF_TIMEOUT   = 15;
  // Width of the shared setup/wait counter.
  localparam int unsigned WCNT_W        = 4;

  // Active-low one-hot chip select produced by an Am25LS2548 for a given
  // select code when all four enables are in their active state.
  function automatic logic [7:0] decode_y(input logic [2:0] sel,
                                          input logic       en);
    logic [7:0] y;
    y = 8'hFF;
    if (en) y[sel] = 1'b0;
    return y;
  endfunction

endpackage

// File: rtl/am25ls2548_initiator.sv
// Bus initiator that drives an Am25LS2548 chip-select decoder: presents a
// select code with the decoder enables, waits a setup time, asserts the
// read or write strobe until the decoder acknowledges (or a timeout), holds
// the select for one cycle and then reports completion.
//
// Handshake: a cycle is requested by req=1 while busy=0 (IDLE); the request
// is accepted on that rising edge and busy rises with it. req is ignored
// while busy=1. Completion is a one-cycle done pulse in IDLE; a req held
// high in that cycle is accepted immediately (back-to-back). ack_ is an
// active-low, clk-synchronous acknowledge and is only looked at in STROBE.
module am25ls2548_initiator
  import am25ls2548_pkg::*;
#(
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       req,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  input  logic       ack_,
  output logic       c,
  output logic       b,
  output logic       a,
  output logic       e1_,
  output logic       e2_,
  output logic       e3,
  output logic       e4,
  output logic       rd_,
  output logic       wr_,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       tmo,
  output state_t     state_dbg
);

  // Terminal counts for the shared counter: SETUP ends when it reaches
  // SETUP_CYC-1, STROBE times out when it reaches TIMEOUT-1.
  localparam logic [WCNT_W-1:0] SETUP_LAST = WCNT_W'(SETUP_CYC - 1);
  localparam logic [WCNT_W-1:0] TMO_LAST   = WCNT_W'(TIMEOUT - 1);

  state_t            state;
  logic [WCNT_W-1:0] wcnt;    // setup / strobe wait counter
  logic              cyc_we;  // cycle type latched with the request

  assign state_dbg = state;

  // Bus-cycle sequencer; every output is a register so the decoder sees
  // glitch-free enables, select code and strobes.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state  <= ST_IDLE;
      wcnt   <= '0;
      cyc_we <= 1'b0;
      c      <= 1'b0;
      b      <= 1'b0;
      a      <= 1'b0;
      e1_    <= 1'b1;
      e2_    <= 1'b1;
      e3     <= 1'b0;
      e4     <= 1'b0;
      rd_    <= 1'b1;
      wr_    <= 1'b1;
      rdata  <= 8'h00;
      busy   <= 1'b0;
      done   <= 1'b0;
      tmo    <= 1'b0;
    end else begin
      // done is a single-cycle pulse raised only on the HOLD -> IDLE step.
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            {c, b, a} <= addr;
            cyc_we    <= we;
            e1_       <= 1'b0;
            e2_       <= 1'b0;
            e3        <= 1'b1;
            e4        <= 1'b1;
            busy      <= 1'b1;
            tmo       <= 1'b0;
            wcnt      <= '0;
            state     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (wcnt == SETUP_LAST) begin
            // Counter is reused for the strobe wait, so restart it here.
            wcnt  <= '0;
            rd_   <= cyc_we;
            wr_   <= ~cyc_we;
            state <= ST_STROBE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end

        ST_STROBE: begin
          if (!ack_) begin
            // Acknowledge is tested first so it wins over a same-cycle timeout.
            if (!cyc_we) rdata <= din;
            rd_   <= 1'b1;
            wr_   <= 1'b1;
            state <= ST_HOLD;
          end else if (wcnt == TMO_LAST) begin
            tmo   <= 1'b1;
            rd_   <= 1'b1;
            wr_   <= 1'b1;
            state <= ST_HOLD;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end

        ST_HOLD: begin
          // Select code is left as-is; only the enables drop back.
          e1_   <= 1'b1;
          e2_   <= 1'b1;
          e3    <= 1'b0;
          e4    <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
          wcnt  <= '0;
          state <= ST_IDLE;
        end

        default: begin
          e1_   <= 1'b1;
          e2_   <= 1'b1;
          e3    <= 1'b0;
          e4    <= 1'b0;
          rd_   <= 1'b1;
          wr_   <= 1'b1;
          busy  <= 1'b0;
          wcnt  <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_am25ls2548_initiator.sv
// Self-checking bench for am25ls2548_initiator driving an Am25LS2548
// decoder model: table of directed bus cycles plus hand-written sequences
// for back-to-back requests, ack_ outside the strobe and mid-cycle reset.
module tb_am25ls2548_initiator;
  import am25ls2548_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  logic       req, we, ack_;
  logic [2:0] addr;
  logic [7:0] din;
  logic       c, b, a, e1_, e2_, e3, e4, rd_, wr_;
  logic [7:0] rdata;
  logic       busy, done, tmo;
  state_t     state_dbg;

  am25ls2548_initiator #(
    .SETUP_CYC(DEF_SETUP_CYC),
    .TIMEOUT  (DEF_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_     (rst_),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .din      (din),
    .ack_     (ack_),
    .c        (c),
    .b        (b),
    .a        (a),
    .e1_      (e1_),
    .e2_      (e2_),
    .e3       (e3),
    .e4       (e4),
    .rd_      (rd_),
    .wr_      (wr_),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .tmo      (tmo),
    .state_dbg(state_dbg)
  );

  // ---------------- Am25LS2548 decoder model ----------------
  logic [7:0] y;
  always_comb begin
    y = decode_y({c, b, a}, (!e1_ && !e2_ && e3 && e4));
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [7:0] din;
    int         ack_after;  // strobe cycle in which ack_ is low, 0 = never
    logic       noise;      // req/addr toggling while busy, ack_ low outside STROBE
    logic [7:0] exp_y;
    int         exp_n;      // strobe cycles
    logic [7:0] exp_rdata;
    logic       exp_tmo;
  } vec_t;

  localparam int NVEC = 7;
  vec_t vecs[NVEC];

  // ---------------- driver / monitor for one bus cycle ----------------
  task automatic run_cycle(input vec_t v, input string tag);
    int   edges, rd_cnt, wr_cnt, both, ybad, stb;
    logic seen_done;
    edges = 0; rd_cnt = 0; wr_cnt = 0; both = 0; ybad = 0; stb = 0;
    seen_done = 1'b0;
    @(negedge clk);
    we = v.we; addr = v.addr; din = v.din; req = 1'b1; ack_ = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    req = 1'b0;
    check({tag, " accept busy"}, busy, 1);
    check({tag, " accept tmo clr"}, tmo, 0);
    check({tag, " accept enables"}, {e1_, e2_, e3, e4}, 4'b0011);
    for (int k = 0; k < 60; k++) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (!rd_) rd_cnt++;
      if (!wr_) wr_cnt++;
      if (!rd_ && !wr_) both++;
      if ((!rd_ || !wr_) && (y !== v.exp_y)) ybad++;
      if (!rd_ || !wr_) stb++;
      else stb = 0;
      if (v.ack_after != 0 && stb == v.ack_after) ack_ = 1'b0;
      else if (v.noise && stb == 0) ack_ = 1'b0;
      else ack_ = 1'b1;
      req  = v.noise && (!rd_ || !wr_);
      addr = v.noise ? ~v.addr : v.addr;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    req = 1'b0; ack_ = 1'b1; addr = v.addr;
    check({tag, " done seen"}, seen_done, 1);
    check({tag, " latency"}, edges, DEF_SETUP_CYC + v.exp_n + 2);
    check({tag, " rd_ low cycles"}, rd_cnt, v.we ? 0 : v.exp_n);
    check({tag, " wr_ low cycles"}, wr_cnt, v.we ? v.exp_n : 0);
    check({tag, " both strobes"}, both, 0);
    check({tag, " y bad samples"}, ybad, 0);
    check({tag, " rdata"}, rdata, v.exp_rdata);
    check({tag, " tmo"}, tmo, v.exp_tmo);
    check({tag, " idle cba held"}, {c, b, a}, v.addr);
    check({tag, " idle enables off"}, {e1_, e2_, e3, e4}, 4'b1100);
    check({tag, " idle busy"}, busy, 0);
    @(negedge clk);
    check({tag, " done width"}, done, 0);
    check({tag, " tmo held"}, tmo, v.exp_tmo);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int   dones, gap;
    logic [7:0] y1, y2;
    int   lows, stb;
    logic seen;

    //            we    addr  din    ack noise  y      n   rdata  tmo
    vecs[0] = '{1'b0, 3'd5, 8'hA5,  2, 1'b0, 8'hDF,  2, 8'hA5, 1'b0};
    vecs[1] = '{1'b1, 3'd0, 8'h3C,  0, 1'b0, 8'hFE, 15, 8'hA5, 1'b1};
    vecs[2] = '{1'b0, 3'd7, 8'h5A, 15, 1'b1, 8'h7F, 15, 8'h5A, 1'b0};
    vecs[3] = '{1'b0, 3'd2, 8'h11,  0, 1'b0, 8'hFB, 15, 8'h5A, 1'b1};
    vecs[4] = '{1'b1, 3'd4, 8'hFF,  1, 1'b1, 8'hEF,  1, 8'h5A, 1'b0};
    vecs[5] = '{1'b0, 3'd1, 8'hC3,  1, 1'b0, 8'hFD,  1, 8'hC3, 1'b0};
    vecs[6] = '{1'b0, 3'd6, 8'h00,  3, 1'b0, 8'hBF,  3, 8'h00, 1'b0};

    req = 1'b0; we = 1'b0; addr = 3'd0; din = 8'h00; ack_ = 1'b1;

    // Reset state, observed while rst_ is still low and clocks run.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset state", state_dbg, ST_IDLE);
    check("reset cba", {c, b, a}, 3'b000);
    check("reset enables", {e1_, e2_, e3, e4}, 4'b1100);
    check("reset strobes", {rd_, wr_}, 2'b11);
    check("reset rdata", rdata, 8'h00);
    check("reset flags", {busy, done, tmo}, 3'b000);
    rst_ = 1'b1;

    // ack_ low while idle must not start or complete anything.
    ack_ = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("idle ack_ busy", busy, 0);
    check("idle ack_ done", done, 0);
    check("idle ack_ state", state_dbg, ST_IDLE);
    ack_ = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_cycle(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back: req held high, addr 3 then 6.
    @(negedge clk);
    we = 1'b0; addr = 3'd3; req = 1'b1; ack_ = 1'b1;
    dones = 0; gap = 0; y1 = 8'hFF; y2 = 8'hFF; stb = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        dones++;
        if (dones == 1) addr = 3'd6;
        if (dones == 2) begin
          req = 1'b0;
          break;
        end
      end
      if (dones == 1 && e1_) gap++;
      if (!rd_) begin
        if (dones == 0) y1 = y;
        else y2 = y;
      end
      if (!rd_ || !wr_) stb++;
      else stb = 0;
      ack_ = (stb == 1) ? 1'b0 : 1'b1;
    end
    req = 1'b0; ack_ = 1'b1;
    check("b2b done pulses", dones, 2);
    check("b2b first y", y1, 8'hF7);
    check("b2b second y", y2, 8'hBF);
    check("b2b idle gap", gap, 1);

    // Reset pulsed low during STROBE.
    @(negedge clk);
    we = 1'b0; addr = 3'd4; din = 8'h99; req = 1'b1; ack_ = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (!rd_) lows++;
      if (lows == 2) break;
    end
    check("rst mid strobe reached", lows, 2);
    #2 rst_ = 1'b0;
    #1;
    check("rst async strobes", {rd_, wr_}, 2'b11);
    check("rst async enables", {e1_, e2_, e3, e4}, 4'b1100);
    check("rst async busy", busy, 0);
    check("rst async state", state_dbg, ST_IDLE);
    @(posedge clk);
    @(negedge clk);
    rst_ = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("rst no done", seen, 0);
    check("rst rdata cleared", rdata, 8'h00);
    run_cycle('{1'b0, 3'd2, 8'h77, 2, 1'b0, 8'hFB, 2, 8'h77, 1'b0}, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
